// File: rtl/image_mem_arbiter_if.sv
// image_mem_arbiter_if: core-side request/grant/read-data bus plus the image RAM port.
// The master modport belongs to the cores and RAM; the slave modport belongs to the arbiter.
interface image_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 2
);
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] addr_0;
    logic [AW-1:0] addr_1;
    logic [AW-1:0] addr_2;
    logic [DW-1:0] wd_0;
    logic [DW-1:0] wd_1;
    logic [DW-1:0] wd_2;
    logic [2:0]    gnt;
    logic [2:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rd;

    modport master (
        output req, we, addr_0, addr_1, addr_2, wd_0, wd_1, wd_2, m_rd,
        input  gnt, rvalid, rdata, m_en, m_we, m_addr, m_wd
    );

    modport slave (
        input  req, we, addr_0, addr_1, addr_2, wd_0, wd_1, wd_2, m_rd,
        output gnt, rvalid, rdata, m_en, m_we, m_addr, m_wd
    );
endinterface

// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter: round-robin share of the image RAM among three cores during PROG.
// Define ARB_FIXED_PRIO_EN for fixed priority (core 0 > core 1 > core 2) instead.
module image_mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 2
) (
    input  logic                      i_clk,
    input  logic                      i_clr_n,
    input  logic [1:0]                i_state,
    image_mem_arbiter_if.slave        io_bus,
    output logic [7:0]                o_conflict_cnt
);
    localparam logic [1:0] ST_IN   = 2'b10;
    localparam logic [1:0] ST_PROG = 2'b01;

    logic [2:0]    r_gnt;
    logic [2:0]    r_rd_pend;
    logic [2:0]    r_rvalid;
    logic          r_m_en;
    logic          r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wd;
    logic [7:0]    r_cnt;
    logic [1:0]    r_ptr;

    logic [2:0]    w_req;
    logic [1:0]    w_win;
    logic [2:0]    w_onehot;
    logic          w_grant;
    logic          w_contend;
    logic          w_we_sel;
    logic [AW-1:0] w_addr_sel;
    logic [DW-1:0] w_wd_sel;

    assign w_req = io_bus.req;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = w_req[0] ? 2'd0 : w_req[1] ? 2'd1 : 2'd2;
    end
`else
    logic [1:0] w_nxt1;
    logic [1:0] w_nxt2;
    assign w_nxt1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    assign w_nxt2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
    always_comb begin
        w_win = w_req[w_nxt1] ? w_nxt1 : w_req[w_nxt2] ? w_nxt2 : r_ptr;
    end
`endif

    assign w_onehot   = 3'b001 << w_win;
    assign w_grant    = (i_state == ST_PROG) && (|w_req);
    assign w_contend  = (w_req[0] & w_req[1]) | (w_req[0] & w_req[2]) | (w_req[1] & w_req[2]);
    assign w_we_sel   = io_bus.we[w_win];
    assign w_addr_sel = (w_win == 2'd0) ? io_bus.addr_0 : (w_win == 2'd1) ? io_bus.addr_1 : io_bus.addr_2;
    assign w_wd_sel   = (w_win == 2'd0) ? io_bus.wd_0 : (w_win == 2'd1) ? io_bus.wd_1 : io_bus.wd_2;

    // Address/data hold their last value when idle; only enables are forced low.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_gnt     <= 3'b000;
            r_rd_pend <= 3'b000;
            r_rvalid  <= 3'b000;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wd    <= '0;
            r_ptr     <= 2'd2;
        end else begin
            r_rvalid <= r_rd_pend;
            if (w_grant) begin
                r_gnt     <= w_onehot;
                r_rd_pend <= w_onehot & ~io_bus.we;
                r_m_en    <= 1'b1;
                r_m_we    <= w_we_sel;
                r_m_addr  <= w_addr_sel;
                r_m_wd    <= w_wd_sel;
                r_ptr     <= w_win;
            end else begin
                r_gnt     <= 3'b000;
                r_rd_pend <= 3'b000;
                r_m_en    <= 1'b0;
                r_m_we    <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_cnt <= 8'd0;
        end else if (i_state == ST_IN) begin
            r_cnt <= 8'd0;
        end else if (i_state == ST_PROG && w_contend && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign io_bus.gnt    = r_gnt;
    assign io_bus.rvalid = r_rvalid;
    assign io_bus.rdata  = io_bus.m_rd;
    assign io_bus.m_en   = r_m_en;
    assign io_bus.m_we   = r_m_we;
    assign io_bus.m_addr = r_m_addr;
    assign io_bus.m_wd   = r_m_wd;
    assign o_conflict_cnt = r_cnt;
endmodule
